// File: rtl/sha1_axil_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sha1_axil_pkg
// Description : Shared constants and FSM state types for the SHA-1 AXI4-Lite
//               register slave: address map, CTRL/STATUS bit positions,
//               response code, and write/read channel state enums.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package sha1_axil_pkg;

    // Byte offsets of the register map
    localparam logic [7:0] ADDR_SCRATCH_BASE = 8'h00;
    localparam logic [7:0] ADDR_CTRL         = 8'h10;
    localparam logic [7:0] ADDR_STATUS       = 8'h14;
    localparam logic [7:0] ADDR_BLOCK_BASE   = 8'h40;
    localparam logic [7:0] ADDR_DIGEST_BASE  = 8'h80;

    // Word (32-bit) indices of the same map; decode works on addr[7:2]
    localparam logic [5:0] WORD_SCRATCH_BASE = ADDR_SCRATCH_BASE[7:2];
    localparam logic [5:0] WORD_CTRL         = ADDR_CTRL[7:2];
    localparam logic [5:0] WORD_STATUS       = ADDR_STATUS[7:2];
    localparam logic [5:0] WORD_BLOCK_BASE   = ADDR_BLOCK_BASE[7:2];
    localparam logic [5:0] WORD_DIGEST_BASE  = ADDR_DIGEST_BASE[7:2];

    localparam int NUM_SCRATCH = 4;
    localparam int NUM_BLOCK   = 16;
    localparam int NUM_DIGEST  = 5;

    // CTRL and STATUS bit positions
    localparam int CTRL_NEXT_BIT    = 0;
    localparam int CTRL_INIT_BIT    = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_VALID_BIT = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    // Word index of a byte address; the two low bits are ignored
    function automatic logic [5:0] word_index(input logic [7:0] byte_addr);
        return byte_addr[7:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha1_axil_strb_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sha1_axil_strb_reg
// Description : 32-bit register with per-byte write strobes and synchronous
//               active-high clear.
// Ports       : clk, rst       - clock, synchronous active-high clear
//               i_we           - write enable
//               i_strb[3:0]    - byte lane enables (lane i -> bits 8i+7:8i)
//               i_wdata[31:0]  - write data
//               o_q[31:0]      - register contents
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sha1_axil_strb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [3:0]  i_strb,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_strb[b]) begin
                    r_q[b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/sha1_axil_slave.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sha1_axil_slave
// Description : AXI4-Lite register slave for the SHA-1 core. Provides four
//               scratch registers, CTRL (init/next command pulses), STATUS,
//               a 16-word message block buffer and 5-word digest readback.
// Ports       : S_AXI_*            - AXI4-Lite slave (single-beat transfers)
//               core_block[511:0]  - message block, word 0 in bits [511:480]
//               core_init/next     - one-cycle command pulses to the core
//               core_ready         - core idle
//               core_digest[159:0] - digest, word 0 in bits [159:128]
//               core_digest_valid  - digest valid
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sha1_axil_slave
    import sha1_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [511:0]                    core_block,
    output logic                            core_init,
    output logic                            core_next,
    input  logic                            core_ready,
    input  logic [159:0]                    core_digest,
    input  logic                            core_digest_valid
);

    //--------------------------------------------------------------------------
    // Write channel FSM
    //--------------------------------------------------------------------------
    wr_state_e   r_wr_state;
    wr_state_e   w_wr_state_nxt;
    logic        w_wr_accept;
    logic        w_wr_commit;
    logic        w_awready;
    logic        w_bvalid;

    logic [5:0]  r_wr_word;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_accept    = 1'b0;
        w_wr_commit    = 1'b0;
        w_awready      = 1'b0;
        w_bvalid       = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                // Address and data must both be present; neither is taken alone
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    w_wr_accept    = 1'b1;
                    w_wr_state_nxt = W_ACK;
                end
            end
            W_ACK: begin
                w_awready      = 1'b1;
                w_wr_commit    = 1'b1;
                w_wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (S_AXI_BREADY) begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Capture the write at acceptance so the register update does not
    // depend on the master holding the bus stable through the ACK cycle.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wr_word <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_wr_accept) begin
            r_wr_word <= word_index(S_AXI_AWADDR[7:0]);
            r_wdata   <= S_AXI_WDATA;
            r_wstrb   <= S_AXI_WSTRB;
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_awready;
    assign S_AXI_BVALID  = w_bvalid;
    assign S_AXI_BRESP   = RESP_OKAY;

    //--------------------------------------------------------------------------
    // Write decode
    //--------------------------------------------------------------------------
    logic                   w_wr_scratch_hit;
    logic                   w_wr_block_hit;
    logic [NUM_SCRATCH-1:0] w_scratch_we;
    logic [NUM_BLOCK-1:0]   w_block_we;
    logic [31:0]            w_scratch_q [NUM_SCRATCH];
    logic [31:0]            w_block_q   [NUM_BLOCK];

    assign w_wr_scratch_hit = w_wr_commit && (r_wr_word[5:2] == WORD_SCRATCH_BASE[5:2]);
    assign w_wr_block_hit   = w_wr_commit && (r_wr_word[5:4] == WORD_BLOCK_BASE[5:4]);

    for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
        assign w_scratch_we[gi] = w_wr_scratch_hit && (r_wr_word[1:0] == 2'(gi));

        sha1_axil_strb_reg u_reg (
            .clk     (S_AXI_ACLK),
            .rst     (S_AXI_ARESET),
            .i_we    (w_scratch_we[gi]),
            .i_strb  (r_wstrb),
            .i_wdata (r_wdata),
            .o_q     (w_scratch_q[gi])
        );
    end

    for (genvar gi = 0; gi < NUM_BLOCK; gi++) begin : g_block
        assign w_block_we[gi] = w_wr_block_hit && (r_wr_word[3:0] == 4'(gi));

        sha1_axil_strb_reg u_reg (
            .clk     (S_AXI_ACLK),
            .rst     (S_AXI_ARESET),
            .i_we    (w_block_we[gi]),
            .i_strb  (r_wstrb),
            .i_wdata (r_wdata),
            .o_q     (w_block_q[gi])
        );

        assign core_block[511 - 32*gi -: 32] = w_block_q[gi];
    end

    //--------------------------------------------------------------------------
    // Command pulses. INIT wins over NEXT; commands while the core is busy
    // are silently dropped (the bus write still completes OKAY).
    //--------------------------------------------------------------------------
    logic w_ctrl_hit;
    logic r_core_init;
    logic r_core_next;

    assign w_ctrl_hit = w_wr_commit && (r_wr_word == WORD_CTRL) && r_wstrb[0] && core_ready;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_core_init <= 1'b0;
            r_core_next <= 1'b0;
        end else begin
            r_core_init <= w_ctrl_hit && r_wdata[CTRL_INIT_BIT];
            r_core_next <= w_ctrl_hit && !r_wdata[CTRL_INIT_BIT] && r_wdata[CTRL_NEXT_BIT];
        end
    end

    assign core_init = r_core_init;
    assign core_next = r_core_next;

    //--------------------------------------------------------------------------
    // Read channel FSM
    //--------------------------------------------------------------------------
    rd_state_e   r_rd_state;
    rd_state_e   w_rd_state_nxt;
    logic        w_rd_accept;
    logic        w_rd_latch;
    logic        w_arready;
    logic        w_rvalid;
    logic [5:0]  r_rd_word;
    logic [31:0] r_rdata;
    logic [31:0] w_rd_mux;
    logic [31:0] w_digest_word [NUM_DIGEST];

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_accept    = 1'b0;
        w_rd_latch     = 1'b0;
        w_arready      = 1'b0;
        w_rvalid       = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    w_rd_accept    = 1'b1;
                    w_rd_state_nxt = R_ACK;
                end
            end
            R_ACK: begin
                w_arready      = 1'b1;
                w_rd_latch     = 1'b1;
                w_rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (S_AXI_RREADY) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_DIGEST; gi++) begin : g_digest
        assign w_digest_word[gi] = core_digest[159 - 32*gi -: 32];
    end

    // Read mux; STATUS and DIGEST are live inputs sampled only when RDATA
    // is latched.
    always_comb begin
        w_rd_mux = '0;
        if (r_rd_word[5:2] == WORD_SCRATCH_BASE[5:2]) begin
            w_rd_mux = w_scratch_q[r_rd_word[1:0]];
        end else if (r_rd_word == WORD_STATUS) begin
            w_rd_mux[STATUS_BUSY_BIT]  = !core_ready;
            w_rd_mux[STATUS_VALID_BIT] = core_digest_valid;
        end else if (r_rd_word[5:4] == WORD_BLOCK_BASE[5:4]) begin
            w_rd_mux = w_block_q[r_rd_word[3:0]];
        end else if ((r_rd_word[5:3] == WORD_DIGEST_BASE[5:3]) && (r_rd_word[2:0] < 3'(NUM_DIGEST))) begin
            w_rd_mux = w_digest_word[r_rd_word[2:0]];
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rd_word <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_rd_accept) begin
                r_rd_word <= word_index(S_AXI_ARADDR[7:0]);
            end
            if (w_rd_latch) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = w_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = RESP_OKAY;

    // Protection bits and byte offsets within a word carry no meaning here
    logic w_unused;
    assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_AWPROT, S_AXI_ARADDR[1:0], S_AXI_ARPROT};

endmodule
`default_nettype wire

// File: tb/tb_sha1_axil_slave.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_sha1_axil_slave
// Description : Self-checking bench for sha1_axil_slave with a behavioural
//               register-map model and randomized traffic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_sha1_axil_slave;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [511:0] core_block;
    logic         core_init;
    logic         core_next;
    logic         core_ready;
    logic [159:0] core_digest;
    logic         core_digest_valid;

    int n_cmp = 0;
    int n_err = 0;
    int init_cnt = 0;
    int next_cnt = 0;

    // Behavioural model of the R/W register contents
    logic [31:0] m_scratch [4];
    logic [31:0] m_block   [16];

    sha1_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (8)
    ) dut (
        .S_AXI_ACLK        (clk),
        .S_AXI_ARESET      (rst),
        .S_AXI_AWADDR      (awaddr),
        .S_AXI_AWPROT      (awprot),
        .S_AXI_AWVALID     (awvalid),
        .S_AXI_AWREADY     (awready),
        .S_AXI_WDATA       (wdata),
        .S_AXI_WSTRB       (wstrb),
        .S_AXI_WVALID      (wvalid),
        .S_AXI_WREADY      (wready),
        .S_AXI_BRESP       (bresp),
        .S_AXI_BVALID      (bvalid),
        .S_AXI_BREADY      (bready),
        .S_AXI_ARADDR      (araddr),
        .S_AXI_ARPROT      (arprot),
        .S_AXI_ARVALID     (arvalid),
        .S_AXI_ARREADY     (arready),
        .S_AXI_RDATA       (rdata),
        .S_AXI_RRESP       (rresp),
        .S_AXI_RVALID      (rvalid),
        .S_AXI_RREADY      (rready),
        .core_block        (core_block),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_ready        (core_ready),
        .core_digest       (core_digest),
        .core_digest_valid (core_digest_valid)
    );

    always #5 clk = ~clk;

    // Each negedge with a pulse high counts one cycle of pulse width
    always @(negedge clk) begin
        if (core_init) init_cnt++;
        if (core_next) next_cnt++;
    end

    //--------------------------------------------------------------------------
    // Reference model
    //--------------------------------------------------------------------------
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s);
        int w;
        w = int'(addr) / 4;
        if (w < 4) m_scratch[w] = merge(m_scratch[w], d, s);
        else if (w >= 16 && w < 32) m_block[w-16] = merge(m_block[w-16], d, s);
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        int w;
        logic [159:0] dg;
        w = int'(addr) / 4;
        if (w < 4) return m_scratch[w];
        if (w == 5) return {30'd0, core_digest_valid, !core_ready};
        if (w >= 16 && w < 32) return m_block[w-16];
        if (w >= 32 && w < 37) begin
            dg = core_digest << (32 * (w - 32));
            return dg[159:128];
        end
        return 32'd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_scratch[i] = '0;
        for (int i = 0; i < 16; i++) m_block[i] = '0;
    endtask

    //--------------------------------------------------------------------------
    // Bus driver
    //--------------------------------------------------------------------------
    function automatic logic sig(input int which);
        case (which)
            0: return awready;
            1: return bvalid;
            2: return arready;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_high(input int which, input string what);
        int n = 0;
        while (!sig(which) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sig(which)) begin
            n_cmp++; n_err++;
            $display("FAIL timeout_%s: observed low after %0d cycles, required high", what, n);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        awaddr = addr; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        wait_high(0, "awready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_high(1, "bvalid");
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] resp);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        wait_high(2, "arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_high(3, "rvalid");
        d = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    //--------------------------------------------------------------------------
    // Tests
    //--------------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        n_cmp++;
        if ({awready, wready, bvalid, arready, rvalid, core_init, core_next} !== 7'd0 || rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: observed aw=%b w=%b b=%b ar=%b r=%b init=%b next=%b rdata=%h, required all 0",
                     awready, wready, bvalid, arready, rvalid, core_init, core_next, rdata);
        end
        n_cmp++;
        if (core_block !== 512'd0) begin
            n_err++;
            $display("FAIL reset_block: observed %h, required 0", core_block);
        end
        axi_read(8'h00, d, r);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL reset_scratch0: observed %h, required 00000000", d);
        end
    endtask

    task automatic test_scratch();
        logic [31:0] vals [4];
        logic [31:0] d;
        logic [1:0]  r;
        vals[0] = 32'h0101FFFF; vals[1] = 32'habcd0001; vals[2] = 32'hdead0011; vals[3] = 32'hbeef0011;
        for (int i = 0; i < 4; i++) begin
            axi_write(8'(i*4), vals[i], 4'hF, r);
            model_write(8'(i*4), vals[i], 4'hF);
            n_cmp++;
            if (r !== 2'b00) begin
                n_err++;
                $display("FAIL scratch_bresp[%0d]: observed %b, required 00", i, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(8'(i*4), d, r);
            n_cmp++;
            if (d !== vals[i] || r !== 2'b00) begin
                n_err++;
                $display("FAIL scratch_read[%0d]: observed %h/%b, required %h/00", i, d, r, vals[i]);
            end
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h40, 32'hFFFFFFFF, 4'hF, r);
        model_write(8'h40, 32'hFFFFFFFF, 4'hF);
        axi_write(8'h40, 32'h12345678, 4'b0101, r);
        model_write(8'h40, 32'h12345678, 4'b0101);
        axi_read(8'h40, d, r);
        n_cmp++;
        if (d !== 32'hFF34FF78) begin
            n_err++;
            $display("FAIL strobe_read: observed %h, required ff34ff78", d);
        end
        n_cmp++;
        if (core_block[511:480] !== 32'hFF34FF78) begin
            n_err++;
            $display("FAIL strobe_block0: observed %h, required ff34ff78", core_block[511:480]);
        end
        axi_write(8'h40, 32'h0, 4'h0, r);
        axi_read(8'h40, d, r);
        n_cmp++;
        if (d !== 32'hFF34FF78 || r !== 2'b00) begin
            n_err++;
            $display("FAIL strobe_zero: observed %h/%b, required ff34ff78/00", d, r);
        end
    endtask

    task automatic ctrl_case(input string name, input logic rdy, input logic [31:0] d,
                             input logic [3:0] s, input int exp_init, input int exp_next);
        int i0, n0;
        logic [1:0] r;
        core_ready = rdy;
        i0 = init_cnt; n0 = next_cnt;
        axi_write(8'h10, d, s, r);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (init_cnt - i0 != exp_init || next_cnt - n0 != exp_next || r !== 2'b00) begin
            n_err++;
            $display("FAIL ctrl_%s: observed init=%0d next=%0d bresp=%b, required init=%0d next=%0d bresp=00",
                     name, init_cnt - i0, next_cnt - n0, r, exp_init, exp_next);
        end
    endtask

    task automatic test_command();
        logic [31:0] d;
        logic [1:0]  r;
        ctrl_case("init_prio", 1'b1, 32'h3, 4'hF, 1, 0);
        ctrl_case("next",      1'b1, 32'h1, 4'hF, 0, 1);
        ctrl_case("busy_drop", 1'b0, 32'h3, 4'hF, 0, 0);
        ctrl_case("no_lane0",  1'b1, 32'h3, 4'hE, 0, 0);
        axi_read(8'h10, d, r);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL ctrl_readback: observed %h, required 00000000", d);
        end
    endtask

    task automatic test_digest_status();
        logic [31:0] exp [5];
        logic [31:0] d;
        logic [1:0]  r;
        exp[0] = 32'ha9993e36; exp[1] = 32'h4706816a; exp[2] = 32'hba3e2571;
        exp[3] = 32'h7850c26c; exp[4] = 32'h9cd0d89d;
        core_digest = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
        core_digest_valid = 1'b1;
        core_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            axi_read(8'(8'h80 + i*4), d, r);
            n_cmp++;
            if (d !== exp[i] || r !== 2'b00) begin
                n_err++;
                $display("FAIL digest[%0d]: observed %h/%b, required %h/00", i, d, r, exp[i]);
            end
        end
        axi_read(8'h14, d, r);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++;
            $display("FAIL status_valid: observed %h, required 00000002", d);
        end
        core_ready = 1'b0; core_digest_valid = 1'b0;
        axi_read(8'h14, d, r);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL status_busy: observed %h, required 00000001", d);
        end
        core_ready = 1'b1;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  r;
        // Write response held off
        awaddr = 8'h0C; wdata = 32'h600DF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        wait_high(0, "awready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(8'h0C, 32'h600DF00D, 4'hF);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bvalid !== 1'b1 || bresp !== 2'b00) begin
                n_err++;
                $display("FAIL bp_bvalid[%0d]: observed %b/%b, required 1/00", i, bvalid, bresp);
            end
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_bvalid_drop: observed %b, required 0", bvalid);
        end
        // Read data held off
        araddr = 8'h0C; arvalid = 1'b1; rready = 1'b0;
        wait_high(2, "arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_high(3, "rvalid");
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rvalid !== 1'b1 || rdata !== 32'h600DF00D) begin
                n_err++;
                $display("FAIL bp_rdata[%0d]: observed %b/%h, required 1/600df00d", i, rvalid, rdata);
            end
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        // Address without data is not accepted
        awaddr = 8'h08; wdata = 32'hCAFE0008; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (awready !== 1'b0 || wready !== 1'b0) begin
                n_err++;
                $display("FAIL aw_alone[%0d]: observed awready=%b wready=%b, required 0/0", i, awready, wready);
            end
        end
        wvalid = 1'b1; bready = 1'b1;
        wait_high(0, "awready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_high(1, "bvalid");
        @(posedge clk); #1;
        bready = 1'b0;
        model_write(8'h08, 32'hCAFE0008, 4'hF);
        axi_read(8'h08, d, r);
        n_cmp++;
        if (d !== 32'hCAFE0008) begin
            n_err++;
            $display("FAIL aw_then_w: observed %h, required cafe0008", d);
        end
        // Unmapped address
        axi_write(8'hC0, 32'hFFFFFFFF, 4'hF, r);
        n_cmp++;
        if (r !== 2'b00) begin
            n_err++;
            $display("FAIL unmapped_bresp: observed %b, required 00", r);
        end
        axi_read(8'hC0, d, r);
        n_cmp++;
        if (d !== 32'd0 || r !== 2'b00) begin
            n_err++;
            $display("FAIL unmapped_read: observed %h/%b, required 00000000/00", d, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] old_val, d;
        logic [1:0]  wr, rr;
        old_val = model_read(8'h08);
        fork
            axi_write(8'h08, 32'h13572468, 4'hF, wr);
            axi_read(8'h08, d, rr);
        join
        model_write(8'h08, 32'h13572468, 4'hF);
        n_cmp++;
        if (d !== old_val) begin
            n_err++;
            $display("FAIL simul_rw_old: observed %h, required %h", d, old_val);
        end
        axi_read(8'h08, d, rr);
        n_cmp++;
        if (d !== 32'h13572468) begin
            n_err++;
            $display("FAIL simul_rw_new: observed %h, required 13572468", d);
        end
    endtask

    task automatic test_random();
        logic [7:0]  addr;
        logic [31:0] d, exp;
        logic [3:0]  s;
        logic [1:0]  r;
        for (int i = 0; i < 80; i++) begin
            core_ready = 1'($urandom_range(0, 1));
            core_digest_valid = 1'($urandom_range(0, 1));
            core_digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
            addr = 8'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(addr, d, s, r);
                model_write(addr, d, s);
                n_cmp++;
                if (r !== 2'b00) begin
                    n_err++;
                    $display("FAIL rand_bresp[%0d] @%h: observed %b, required 00", i, addr, r);
                end
            end else begin
                exp = model_read(addr);
                axi_read(addr, d, r);
                n_cmp++;
                if (d !== exp || r !== 2'b00) begin
                    n_err++;
                    $display("FAIL rand_read[%0d] @%h: observed %h/%b, required %h/00", i, addr, d, r, exp);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (core_block[511 - 32*i -: 32] !== m_block[i]) begin
                n_err++;
                $display("FAIL rand_core_block[%0d]: observed %h, required %h", i, core_block[511 - 32*i -: 32], m_block[i]);
            end
        end
        core_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h00, 32'h11112222, 4'hF, r);
        awaddr = 8'h00; wdata = 32'h5A5A1234; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        wait_high(0, "awready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_high(1, "bvalid");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        n_cmp++;
        if (bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_bvalid: observed %b, required 0", bvalid);
        end
        axi_read(8'h00, d, r);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++;
            $display("FAIL rst_mid_scratch0: observed %h, required 00000000", d);
        end
        axi_write(8'h04, 32'h0BADBEEF, 4'hF, r);
        model_write(8'h04, 32'h0BADBEEF, 4'hF);
        axi_read(8'h04, d, r);
        n_cmp++;
        if (d !== 32'h0BADBEEF || r !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_fresh: observed %h/%b, required 0badbeef/00", d, r);
        end
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        core_ready = 1'b1; core_digest = '0; core_digest_valid = 1'b0;
        model_clear();
        do_reset();

        test_reset();
        test_scratch();
        test_strobe();
        test_command();
        test_digest_status();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
